// File: rtl/video_param_pkg.sv
// Shared constants and types for the video parameter controller: parameter
// indices, per-parameter limits, reset defaults and the auto-repeat state set.
package video_param_pkg;

  localparam int PARAM_N = 4;
  localparam int CNT_W   = 24;

  localparam logic [1:0] PIDX_THRESH   = 2'd0;
  localparam logic [1:0] PIDX_BRIGHT   = 2'd1;
  localparam logic [1:0] PIDX_CONTRAST = 2'd2;
  localparam logic [1:0] PIDX_MODE     = 2'd3;

  localparam logic [7:0] PMAX_THRESH   = 8'd255;
  localparam logic [7:0] PMAX_BRIGHT   = 8'd255;
  localparam logic [7:0] PMAX_CONTRAST = 8'd255;
  localparam logic [7:0] PMAX_MODE     = 8'd3;

  localparam logic [7:0] DEF_THRESH    = 8'd16;
  localparam logic [7:0] DEF_BRIGHT    = 8'd0;
  localparam logic [7:0] DEF_CONTRAST  = 8'd128;
  localparam logic [7:0] DEF_MODE      = 8'd0;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  function automatic logic [7:0] param_max(input logic [1:0] idx);
    case (idx)
      PIDX_THRESH:   return PMAX_THRESH;
      PIDX_BRIGHT:   return PMAX_BRIGHT;
      PIDX_CONTRAST: return PMAX_CONTRAST;
      default:       return PMAX_MODE;
    endcase
  endfunction

endpackage

// File: rtl/video_param_ctrl_if.sv
// Host register-write port: valid/ready handshake carrying a parameter index
// and its 8-bit value.
interface video_param_ctrl_if;
  logic       valid;
  logic       ready;
  logic [1:0] addr;
  logic [7:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/video_param_ctrl_btn_autorepeat.sv
// Hold-to-repeat for one debounced button: a step on press, another after
// REPEAT_DELAY cycles held, then one every REPEAT_PERIOD cycles until release.
module btn_autorepeat #(
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 2_500_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_step
);
  import video_param_pkg::*;

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             r_btn_q0, r_btn_q1;
  logic             w_rise;
  rpt_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  assign w_rise = r_btn_q0 & ~r_btn_q1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_btn_q0 <= 1'b0;
      r_btn_q1 <= 1'b0;
      r_state  <= RPT_IDLE;
      r_cnt    <= '0;
    end else begin
      r_btn_q0 <= i_btn;
      r_btn_q1 <= r_btn_q0;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Release wins in every state; the counter is only meaningful while held.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_step      = 1'b0;
    if (!r_btn_q0) begin
      w_state_nxt = RPT_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        RPT_IDLE: begin
          if (w_rise) begin
            w_state_nxt = RPT_DELAY;
            w_cnt_nxt   = '0;
            o_step      = 1'b1;
          end
        end
        RPT_DELAY: begin
          if (r_cnt == DELAY_LAST) begin
            w_state_nxt = RPT_REPEAT;
            w_cnt_nxt   = '0;
            o_step      = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (r_cnt == PERIOD_LAST) begin
            w_cnt_nxt = '0;
            o_step    = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = RPT_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/video_param_ctrl.sv
// Parameter staging bank fed by buttons and host writes; staged values are
// copied to the active outputs only on a VSYNC rising edge.
module video_param_ctrl #(
  parameter int         REPEAT_DELAY  = 12_500_000,
  parameter int         REPEAT_PERIOD = 2_500_000,
  parameter logic [7:0] DEF_THRESH    = video_param_pkg::DEF_THRESH,
  parameter logic [7:0] DEF_BRIGHT    = video_param_pkg::DEF_BRIGHT,
  parameter logic [7:0] DEF_CONTRAST  = video_param_pkg::DEF_CONTRAST,
  parameter logic [7:0] DEF_MODE      = video_param_pkg::DEF_MODE
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_btn_inc,
  input  logic                     i_btn_dec,
  input  logic                     i_btn_sel,
  video_param_ctrl_if.slave        host,
  input  logic                     i_vsync,
  output logic [1:0]               o_sel,
  output logic [7:0]               o_sobel_thresh,
  output logic [7:0]               o_brightness,
  output logic [7:0]               o_contrast,
  output logic [1:0]               o_mode,
  output logic                     o_pending
);
  import video_param_pkg::*;

  logic       w_inc_step, w_dec_step;
  logic       r_sel_q0, r_sel_q1, w_sel_rise;
  logic [1:0] r_sel;
  logic       r_vsync_d, w_vsync_rise, r_commit;
  logic       w_host_acc;
  logic       r_pending, w_pending_nxt;
  logic [7:0] r_stage      [PARAM_N];
  logic [7:0] r_active     [PARAM_N];
  logic [7:0] w_stage_nxt  [PARAM_N];
  logic [7:0] w_active_nxt [PARAM_N];

  function automatic logic [7:0] def_val(input logic [1:0] idx);
    case (idx)
      PIDX_THRESH:   return DEF_THRESH;
      PIDX_BRIGHT:   return DEF_BRIGHT;
      PIDX_CONTRAST: return DEF_CONTRAST;
      default:       return DEF_MODE;
    endcase
  endfunction

  function automatic logic [7:0] sat_step(input logic [7:0] v, input logic [7:0] vmax,
                                          input logic up);
    if (up) return (v >= vmax) ? vmax : v + 8'd1;
    else    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

  btn_autorepeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_inc (
    .i_clk (i_clk), .i_rst (i_rst), .i_btn (i_btn_inc), .o_step (w_inc_step)
  );

  btn_autorepeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_dec (
    .i_clk (i_clk), .i_rst (i_rst), .i_btn (i_btn_dec), .o_step (w_dec_step)
  );

  assign w_sel_rise   = r_sel_q0 & ~r_sel_q1;
  assign w_vsync_rise = i_vsync & ~r_vsync_d;
  // Writes are held off during the copy cycle so none can land mid-commit.
  assign host.ready   = ~r_commit;
  assign w_host_acc   = host.valid & ~r_commit;

  always_comb begin
    w_pending_nxt = 1'b0;
    for (int i = 0; i < PARAM_N; i++) begin
      w_stage_nxt[i]  = r_stage[i];
      w_active_nxt[i] = r_commit ? r_stage[i] : r_active[i];
      if (w_host_acc && host.addr == 2'(i)) begin
        w_stage_nxt[i] = (2'(i) == PIDX_MODE) ? {6'd0, host.data[1:0]} : host.data;
      end else if (r_sel == 2'(i) && (w_inc_step ^ w_dec_step)) begin
        w_stage_nxt[i] = sat_step(r_stage[i], param_max(2'(i)), w_inc_step);
      end
      if (w_stage_nxt[i] != w_active_nxt[i]) w_pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < PARAM_N; i++) begin
        r_stage[i]  <= def_val(2'(i));
        r_active[i] <= def_val(2'(i));
      end
      r_sel_q0  <= 1'b0;
      r_sel_q1  <= 1'b0;
      r_sel     <= 2'd0;
      r_vsync_d <= 1'b0;
      r_commit  <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      for (int i = 0; i < PARAM_N; i++) begin
        r_stage[i]  <= w_stage_nxt[i];
        r_active[i] <= w_active_nxt[i];
      end
      r_sel_q0  <= i_btn_sel;
      r_sel_q1  <= r_sel_q0;
      r_sel     <= w_sel_rise ? r_sel + 2'd1 : r_sel;
      r_vsync_d <= i_vsync;
      r_commit  <= w_vsync_rise;
      r_pending <= w_pending_nxt;
    end
  end

  assign o_sel          = r_sel;
  assign o_sobel_thresh = r_active[PIDX_THRESH];
  assign o_brightness   = r_active[PIDX_BRIGHT];
  assign o_contrast     = r_active[PIDX_CONTRAST];
  assign o_mode         = r_active[PIDX_MODE][1:0];
  assign o_pending      = r_pending;

endmodule

// File: tb/tb_video_param_ctrl.sv
// Directed bench for video_param_ctrl: a cycle-level reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_video_param_ctrl;

  localparam int D = 20;
  localparam int P = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_inc = 1'b0, btn_dec = 1'b0, btn_sel = 1'b0, vsync = 1'b0;
  logic [1:0] o_sel, o_mode;
  logic [7:0] o_sobel_thresh, o_brightness, o_contrast;
  logic       o_pending;

  video_param_ctrl_if host_if();

  always #5 clk = ~clk;

  video_param_ctrl #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_btn_inc      (btn_inc),
    .i_btn_dec      (btn_dec),
    .i_btn_sel      (btn_sel),
    .host           (host_if),
    .i_vsync        (vsync),
    .o_sel          (o_sel),
    .o_sobel_thresh (o_sobel_thresh),
    .o_brightness   (o_brightness),
    .o_contrast     (o_contrast),
    .o_mode         (o_mode),
    .o_pending      (o_pending)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: button levels as seen one cycle late, hold lengths,
  // staged/active parameter values.
  bit m_inc_lvl, m_dec_lvl, m_sel_lvl, m_sel_prev, m_vs_d, m_commit, m_pend;
  int m_inc_k, m_dec_k, m_sel;
  int m_stage [4];
  int m_act   [4];

  bit c_inc, c_dec, c_acc, c_pend;
  int c_sel;
  int c_stage [4];
  int c_act   [4];

  function automatic bit rpt_fires(input bit lvl, input int k);
    return lvl && (k == 0 || k == D || (k > D && (k - D) % P == 0));
  endfunction

  function automatic int pmax(input int i);
    return (i == 3) ? 3 : 255;
  endfunction

  always_comb begin
    c_inc  = rpt_fires(m_inc_lvl, m_inc_k);
    c_dec  = rpt_fires(m_dec_lvl, m_dec_k);
    c_acc  = host_if.valid && !m_commit;
    c_sel  = (m_sel_lvl && !m_sel_prev) ? (m_sel + 1) % 4 : m_sel;
    c_pend = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c_act[i]   = m_commit ? m_stage[i] : m_act[i];
      c_stage[i] = m_stage[i];
      if (c_acc && int'(host_if.addr) == i)
        c_stage[i] = (i == 3) ? int'(host_if.data) % 4 : int'(host_if.data);
      else if (m_sel == i && c_inc != c_dec)
        c_stage[i] = c_inc ? ((m_stage[i] + 1 > pmax(i)) ? pmax(i) : m_stage[i] + 1)
                           : ((m_stage[i] == 0) ? 0 : m_stage[i] - 1);
      if (c_stage[i] != c_act[i]) c_pend = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_inc_lvl <= 0; m_dec_lvl <= 0; m_sel_lvl <= 0; m_sel_prev <= 0;
      m_inc_k <= 0; m_dec_k <= 0; m_sel <= 0;
      m_vs_d <= 0; m_commit <= 0; m_pend <= 0;
      m_stage[0] <= 16; m_stage[1] <= 0; m_stage[2] <= 128; m_stage[3] <= 0;
      m_act[0]   <= 16; m_act[1]   <= 0; m_act[2]   <= 128; m_act[3]   <= 0;
    end else begin
      m_inc_k    <= m_inc_lvl ? m_inc_k + 1 : 0;
      m_dec_k    <= m_dec_lvl ? m_dec_k + 1 : 0;
      m_inc_lvl  <= btn_inc;
      m_dec_lvl  <= btn_dec;
      m_sel_prev <= m_sel_lvl;
      m_sel_lvl  <= btn_sel;
      m_sel      <= c_sel;
      m_vs_d     <= vsync;
      m_commit   <= vsync && !m_vs_d;
      m_pend     <= c_pend;
      m_stage    <= c_stage;
      m_act      <= c_act;
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      check("model sel",      int'(o_sel),          m_sel);
      check("model thresh",   int'(o_sobel_thresh), m_act[0]);
      check("model bright",   int'(o_brightness),   m_act[1]);
      check("model contrast", int'(o_contrast),     m_act[2]);
      check("model mode",     int'(o_mode),         m_act[3]);
      check("model pending",  int'(o_pending),      int'(m_pend));
      check("model ready",    int'(host_if.ready),  m_commit ? 0 : 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input int which, input int hold);
    case (which)
      0: btn_inc = 1'b1;
      1: btn_dec = 1'b1;
      default: btn_sel = 1'b1;
    endcase
    tick(hold);
    btn_inc = 1'b0; btn_dec = 1'b0; btn_sel = 1'b0;
    tick(3);
  endtask

  task automatic commit();
    vsync = 1'b1;
    tick(1);
    vsync = 1'b0;
    tick(3);
  endtask

  task automatic host_write(input int addr, input int data);
    host_if.valid = 1'b1;
    host_if.addr  = 2'(addr);
    host_if.data  = 8'(data);
    tick(1);
    host_if.valid = 1'b0;
    tick(2);
  endtask

  task automatic check_defaults(input string tag);
    check({tag, " thresh"},   int'(o_sobel_thresh), 16);
    check({tag, " bright"},   int'(o_brightness),   0);
    check({tag, " contrast"}, int'(o_contrast),     128);
    check({tag, " mode"},     int'(o_mode),         0);
    check({tag, " sel"},      int'(o_sel),          0);
    check({tag, " pending"},  int'(o_pending),      0);
    check({tag, " ready"},    int'(host_if.ready),  1);
  endtask

  initial begin
    host_if.valid = 1'b0;
    host_if.addr  = 2'd0;
    host_if.data  = 8'd0;
    tick(3);
    @(negedge clk);
    check_defaults("reset");
    @(posedge clk); #2;
    rst = 1'b0;
    started = 1'b1;
    tick(2);

    // Three single presses on threshold, then commit latency.
    for (int n = 0; n < 3; n++) press(0, 2);
    @(negedge clk);
    check("thresh before commit", int'(o_sobel_thresh), 16);
    check("pending after incs",   int'(o_pending),      1);
    vsync = 1'b1;
    @(posedge clk); @(negedge clk);
    check("ready in commit cycle", int'(host_if.ready),  0);
    check("thresh in commit cycle", int'(o_sobel_thresh), 16);
    @(posedge clk); @(negedge clk);
    check("thresh after commit",   int'(o_sobel_thresh), 19);
    check("pending after commit",  int'(o_pending),      0);
    check("ready after commit",    int'(host_if.ready),  1);
    vsync = 1'b0;
    tick(2);

    // Select to contrast and hold inc through delay and three repeats.
    press(2, 2);
    @(negedge clk); check("sel step 1", int'(o_sel), 1);
    press(2, 2);
    @(negedge clk); check("sel step 2", int'(o_sel), 2);
    press(0, 36);
    commit();
    @(negedge clk); check("contrast after hold", int'(o_contrast), 133);

    // Mode saturates at 3; host write keeps only the low two bits.
    press(2, 2);
    @(negedge clk); check("sel step 3", int'(o_sel), 3);
    for (int n = 0; n < 4; n++) press(0, 2);
    commit();
    @(negedge clk); check("mode saturated", int'(o_mode), 3);
    host_write(3, 'hFE);
    commit();
    @(negedge clk); check("mode host write", int'(o_mode), 2);
    press(2, 2);
    @(negedge clk); check("sel wraps to 0", int'(o_sel), 0);

    // Host write and button step to the same index: host wins.
    @(posedge clk); #2;
    btn_inc = 1'b1;
    tick(1);
    host_if.valid = 1'b1; host_if.addr = 2'd0; host_if.data = 8'd200;
    tick(1);
    host_if.valid = 1'b0; btn_inc = 1'b0;
    tick(3);
    commit();
    @(negedge clk); check("host beats same-index step", int'(o_sobel_thresh), 200);

    // Host write and button step to different indices: both apply.
    press(2, 2);
    @(posedge clk); #2;
    btn_inc = 1'b1;
    tick(1);
    host_if.valid = 1'b1; host_if.addr = 2'd0; host_if.data = 8'd50;
    tick(1);
    host_if.valid = 1'b0; btn_inc = 1'b0;
    tick(3);
    commit();
    @(negedge clk);
    check("host write other index", int'(o_sobel_thresh), 50);
    check("step other index",       int'(o_brightness),   1);

    // Brightness up to 2, then a long dec hold saturates at 0.
    press(0, 2);
    commit();
    @(negedge clk); check("bright at 2", int'(o_brightness), 2);
    press(1, 40);
    commit();
    @(negedge clk); check("bright dec saturates", int'(o_brightness), 0);

    // Host write presented during the commit cycle waits one cycle.
    @(posedge clk); #2;
    vsync = 1'b1;
    tick(1);
    host_if.valid = 1'b1; host_if.addr = 2'd2; host_if.data = 8'd77;
    @(negedge clk); check("ready low during commit", int'(host_if.ready), 0);
    @(posedge clk); @(negedge clk);
    check("ready back high",          int'(host_if.ready), 1);
    check("contrast not raced",       int'(o_contrast),    133);
    check("pending before late write", int'(o_pending),    0);
    @(posedge clk); #2;
    host_if.valid = 1'b0;
    vsync = 1'b0;
    @(negedge clk);
    check("pending after late write", int'(o_pending),  1);
    check("contrast held",            int'(o_contrast), 133);
    tick(3);
    commit();
    @(negedge clk);
    check("contrast next frame", int'(o_contrast), 77);
    check("pending cleared",     int'(o_pending),  0);

    // Reset in the middle of a DELAY hold.
    @(posedge clk); #2;
    btn_inc = 1'b1;
    tick(8);
    rst = 1'b1;
    @(negedge clk);
    check_defaults("mid-hold reset");
    btn_inc = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(40);
    @(negedge clk);
    check("no step after reset",   int'(o_pending),      0);
    check("thresh after reset",    int'(o_sobel_thresh), 16);
    check("bright after reset",    int'(o_brightness),   0);
    check("sel after reset",       int'(o_sel),          0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
